// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_IDLE,
        ST_BURST
    } rx_state_t;

    // One character is start + 8 data + stop = 10 bit periods.
    function automatic int char_cycles(input int clock, input int rate);
        return 10 * (clock / rate);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO with occupancy count.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_pop;
    logic             wr_en;

    assign valid  = (count != '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && valid;
    // A pop frees the slot the same cycle, so a full FIFO still accepts.
    assign wr_en  = push && (!full || do_pop);
    assign dout   = valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            unique case ({wr_en, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: toggle synchronizer, byte FIFO,
// overflow accounting and inter-burst idle detection.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLOCK         = 50000000,
    parameter int RATE          = 9600,
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_char,
    input  logic                   rx_toggle,
    input  logic                   rx_enable,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [7:0]             drop_count,
    input  logic                   clr_overflow,
    output logic                   idle_timeout
);

    localparam int TERM = TIMEOUT_CHARS * char_cycles(CLOCK, RATE) - 1;
    localparam int TW   = (TERM > 0) ? $clog2(TERM + 1) : 1;

    logic          sync1;
    logic          sync2;
    logic          track;
    logic [1:0]    prime;
    logic          rx_ev;
    logic          push;
    logic          full;
    logic          drop;
    rx_state_t     state;
    logic [TW-1:0] gap;

    // Track follows the synchronizer for two cycles after reset so a
    // toggle line already high at release never looks like an edge.
    assign rx_ev = prime[1] && (sync2 != track);
    assign push  = rx_ev && rx_enable && (state != ST_OFF);
    assign drop  = push && full && !(out_valid && out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            track <= 1'b0;
            prime <= 2'b00;
        end else begin
            sync1 <= rx_toggle;
            sync2 <= sync1;
            prime <= {prime[0], 1'b1};
            track <= prime[1] ? sync2 : sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF)
                drop_count <= drop_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_OFF;
            gap          <= '0;
            idle_timeout <= 1'b0;
        end else begin
            idle_timeout <= 1'b0;
            if (!rx_enable) begin
                state <= ST_OFF;
                gap   <= '0;
            end else begin
                unique case (state)
                    ST_OFF: state <= ST_IDLE;
                    ST_IDLE: begin
                        if (rx_ev) begin
                            state <= ST_BURST;
                            gap   <= '0;
                        end
                    end
                    ST_BURST: begin
                        if (rx_ev) begin
                            gap <= '0;
                        end else if (gap == TW'(TERM)) begin
                            idle_timeout <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            gap <= gap + 1'b1;
                        end
                    end
                    default: state <= ST_OFF;
                endcase
            end
        end
    end

    uart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (rx_char),
        .pop   (out_ready),
        .dout  (out_data),
        .valid (out_valid),
        .full  (full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with directed byte sequences.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_char;
    logic       rx_toggle;
    logic       rx_enable;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clr_overflow;
    logic       idle_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int pulse_cyc = -1;
    int ev_cyc = 0;
    logic [7:0] exp_q [$];

    uart_rx_ctrl #(
        .CLOCK         (1000),
        .RATE          (100),
        .DEPTH         (4),
        .TIMEOUT_CHARS (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_char      (rx_char),
        .rx_toggle    (rx_toggle),
        .rx_enable    (rx_enable),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clr_overflow (clr_overflow),
        .idle_timeout (idle_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every handshake must pop the oldest expected byte.
    always @(negedge clk) begin
        if (!reset && idle_timeout) begin
            pulses = pulses + 1;
            if (pulse_cyc < 0)
                pulse_cyc = cyc;
        end
        if (!reset && out_valid && out_ready) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL pop_unexpected: got %02h, queue empty", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors = errors + 1;
                    $display("FAIL pop_data: got %02h, expected %02h", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit expect_push);
        rx_char   = b;
        rx_toggle = ~rx_toggle;
        if (expect_push)
            exp_q.push_back(b);
    endtask

    task automatic do_reset(input logic init_toggle);
        reset        = 1'b1;
        rx_toggle    = init_toggle;
        rx_char      = 8'h00;
        rx_enable    = 1'b0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        exp_q.delete();
        tick(3);
        reset = 1'b0;
        rx_enable = 1'b1;
        tick(3);
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++)
            tick(1);
        tick(1);
        chk(name, exp_q.size(), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        #2;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_drops", int'(drop_count), 0);
        chk("rst_timeout", int'(idle_timeout), 0);

        // Single byte latency
        do_reset(1'b0);
        send(8'h41, 1'b1);
        tick(2);
        chk("lat_early_valid", int'(out_valid), 0);
        tick(1);
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_data", int'(out_data), 8'h41);
        chk("lat_count", int'(fifo_count), 1);
        drain("drain_single");

        // Overflow: six bytes into four slots
        for (int i = 1; i <= 6; i++) begin
            send(8'(i), i <= 4);
            tick(4);
        end
        tick(2);
        chk("ovf_count", int'(fifo_count), 4);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_drops", int'(drop_count), 2);
        chk("ovf_head", int'(out_data), 8'h01);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        chk("clr_flag", int'(overflow), 0);
        chk("clr_drops", int'(drop_count), 0);
        chk("clr_count", int'(fifo_count), 4);
        drain("drain_ovf");

        // Push and pop together while full
        for (int i = 0; i < 4; i++) begin
            send(8'h11 + 8'(i), 1'b1);
            tick(4);
        end
        chk("full_count", int'(fifo_count), 4);
        send(8'h15, 1'b1);
        tick(2);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("pp_count", int'(fifo_count), 4);
        chk("pp_flag", int'(overflow), 0);
        chk("pp_drops", int'(drop_count), 0);
        drain("drain_pp");

        // Idle timeout after one byte
        do_reset(1'b0);
        out_ready = 1'b1;
        pulses    = 0;
        pulse_cyc = -1;
        send(8'h5A, 1'b1);
        tick(3);
        ev_cyc = cyc;
        tick(199);
        chk("to_early", pulses, 0);
        tick(60);
        chk("to_pulses", pulses, 1);
        chk("to_delay", pulse_cyc - ev_cyc, 200);
        chk("to_state", int'(dut.state), int'(ST_IDLE));
        chk("to_queue", exp_q.size(), 0);
        out_ready = 1'b0;

        // Disabled receiver discards bytes
        rx_enable = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            send(8'hA0 + 8'(i), 1'b0);
            tick(4);
        end
        tick(3);
        rx_enable = 1'b1;
        tick(10);
        chk("off_count", int'(fifo_count), 0);
        chk("off_drops", int'(drop_count), 0);
        chk("off_valid", int'(out_valid), 0);

        // Toggle held high through reset release
        do_reset(1'b1);
        tick(7);
        chk("prime_count", int'(fifo_count), 0);
        chk("prime_valid", int'(out_valid), 0);
        send(8'h77, 1'b1);
        tick(5);
        chk("prime_push", int'(fifo_count), 1);
        chk("prime_data", int'(out_data), 8'h77);
        drain("drain_prime");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
